// File: rtl/branch_update_tracker.sv
// In-order tracker of in-flight branch predictions; drives the predictor update
// port on each resolve, flushes wrong-path entries on mispredict, counts stats.
module branch_update_tracker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_val,
  output logic                     pred_rdy,
  input  logic [31:0]              pred_pc,
  input  logic                     pred_taken,
  input  logic                     res_val,
  output logic                     res_rdy,
  input  logic                     res_taken,
  output logic                     upd_en,
  output logic                     upd_val,
  output logic [31:0]              upd_pc,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         n_branches,
  output logic [CNT_W-1:0]         n_mispred
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0]      pc_mem    [DEPTH];
  logic             taken_mem [DEPTH];
  logic [PTR_W-1:0] head_p0, tail_p0;
  logic [OCC_W-1:0] occ_p0;

  logic             push_req, pop_p0, mis_p0, push_p0;
  logic [31:0]      head_pc;
  logic             head_taken;

  logic             vld_p1, upd_val_p1, mis_p1;
  logic [31:0]      upd_pc_p1;
  logic [CNT_W-1:0] n_br_p1, n_mis_p1;

  assign pred_rdy   = (occ_p0 != OCC_W'(DEPTH));
  assign res_rdy    = (occ_p0 != '0);
  assign head_pc    = pc_mem[head_p0];
  assign head_taken = taken_mem[head_p0];
  assign push_req   = pred_val && pred_rdy;
  assign pop_p0     = res_val && res_rdy;
  assign mis_p0     = pop_p0 && (res_taken != head_taken);
  // A push alongside a mispredicting pop is wrong-path and is dropped.
  assign push_p0    = push_req && !mis_p0;

  always_ff @(posedge clk) begin
    if (push_p0) begin
      pc_mem[tail_p0]    <= pred_pc;
      taken_mem[tail_p0] <= pred_taken;
    end
  end

  // Stage p0 -> p1: pointer/occupancy update and registered predictor update port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_p0    <= '0;
      tail_p0    <= '0;
      occ_p0     <= '0;
      vld_p1     <= 1'b0;
      upd_val_p1 <= 1'b0;
      upd_pc_p1  <= '0;
      mis_p1     <= 1'b0;
      n_br_p1    <= '0;
      n_mis_p1   <= '0;
    end else begin
      if (mis_p0) begin
        head_p0 <= tail_p0;
        occ_p0  <= '0;
      end else begin
        if (pop_p0)  head_p0 <= head_p0 + PTR_W'(1);
        if (push_p0) tail_p0 <= tail_p0 + PTR_W'(1);
        occ_p0 <= occ_p0 + OCC_W'(push_p0) - OCC_W'(pop_p0);
      end
      vld_p1 <= pop_p0;
      mis_p1 <= mis_p0;
      if (pop_p0) begin
        upd_val_p1 <= res_taken;
        upd_pc_p1  <= head_pc;
        n_br_p1    <= sat_inc(n_br_p1);
        if (mis_p0) n_mis_p1 <= sat_inc(n_mis_p1);
      end
    end
  end

  assign upd_en     = vld_p1;
  assign upd_val    = upd_val_p1;
  assign upd_pc     = upd_pc_p1;
  assign mispredict = mis_p1;
  assign occupancy  = occ_p0;
  assign n_branches = n_br_p1;
  assign n_mispred  = n_mis_p1;

endmodule

// File: doc/branch_update_tracker.md
# branch_update_tracker

In-order tracker that holds every in-flight branch prediction between fetch and execute and drives the update port of the branch predictor (PHT) when each branch resolves. Fetch pushes the predicted PC and direction. Execute resolves branches oldest-first with the actual direction. The block then issues a registered update (`update_en`, `update_val`, PC) to the predictor, flags mispredictions, flushes wrong-path entries, and keeps branch and mispredict statistics.

## Interface
Parameters:
- `DEPTH`, 8: number of tracker entries; must be a power of two and ≥ 2.
- `CNT_W`, 32: width of the statistics counters.

Ports:
- `clk`  in  1  the single clock; every register in the block is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; `reset`=0 clears all state immediately.
- `pred_val`  in  1  fetch issues a prediction this cycle.
- `pred_rdy`  out  1  tracker can accept a prediction; high when the tracker is not full.
- `pred_pc`  in  32  PC of the predicted branch.
- `pred_taken`  in  1  predicted direction (the predictor's `prediction` bit).
- `res_val`  in  1  execute resolves the oldest outstanding branch this cycle.
- `res_rdy`  out  1  an entry is available to resolve; high when the tracker is not empty.
- `res_taken`  in  1  actual branch direction.
- `upd_en`  out  1  update strobe to the predictor (`update_en`).
- `upd_val`  out  1  actual direction to train with (`update_val`).
- `upd_pc`  out  32  PC to index the PHT during the update cycle.
- `mispredict`  out  1  one-cycle pulse; the resolved branch was mispredicted.
- `occupancy`  out  $clog2(DEPTH)+1  number of valid entries.
- `n_branches`  out  CNT_W  number of resolved branches, saturating.
- `n_mispred`  out  CNT_W  number of mispredictions, saturating.

## Operation
- **Storage.** A circular FIFO of `DEPTH` entries, each holding {pc[31:0], taken}. It uses a head (read) pointer and a tail (write) pointer, each $clog2(DEPTH) bits and wrapping naturally. A separate occupancy counter distinguishes full from empty.
- **Push.** A push fires when `pred_val && pred_rdy`. The entry is written at the tail, the tail advances, and occupancy increments.
- **Pop.** A pop fires when `res_val && res_rdy`. The head entry is read, the head advances, and occupancy decrements.
- **Ready signals.** `pred_rdy` = (occupancy != DEPTH). `res_rdy` = (occupancy != 0). Both are decoded from registered state only. There is no full/empty bypass:
  - a pop does not free a slot for a push in the same cycle when the tracker is full;
  - a push cannot be resolved in the cycle it arrives.
- **Misprediction.** A mispredict is a pop where `res_taken != head.taken`. On a mispredict:
  - every remaining entry is discarded: head = tail, occupancy = 0;
  - any simultaneous push is dropped, because it is wrong-path. The tail does not advance and no entry is written.
- **Correct prediction.** A push and a pop in the same cycle both take effect, and occupancy is unchanged.
- **Update port.** On every pop, the following are registered for exactly one cycle: `upd_en`=1, `upd_val`=`res_taken`, `upd_pc`=head.pc, and `mispredict`=(res_taken != head.taken). The predictor performs its read-modify-write of the 2-bit counter during this cycle, so `upd_pc` must be muxed onto the predictor PC input while `upd_en`=1.
- **Counters.**
  - `n_branches` increments on every pop.
  - `n_mispred` increments on every mispredicting pop.
  - Both saturate at all-ones and never wrap.
- **Reset.** Asserting `reset`=0 at any time, including mid-flush or mid-update, immediately clears the following and abandons any in-progress update:
  - pointers, occupancy and counters go to 0;
  - `upd_en`, `upd_val`, `upd_pc` and `mispredict` go to 0;
  - `pred_rdy` goes to 1 and `res_rdy` goes to 0.
- **Entry storage at reset.** Entry storage is not reset. Its contents are don't-care until the entry is written.

## Timing
- Pop latency: a pop accepted at edge N produces `upd_en`/`mispredict` in cycle N+1. They are high for one cycle only, unless another pop is accepted at edge N+1, in which case they stay high with new data.
- Push-to-resolvable latency: an entry pushed at edge N gives `res_rdy`=1 from cycle N+1.
- Throughput: one push and one pop per cycle sustained while 0 < occupancy < DEPTH.
- Flush: occupancy reads 0 in the cycle after the mispredicting pop, so `res_rdy`=0 and `pred_rdy`=1.
- Outputs `upd_*`, `mispredict`, the counters and `occupancy` are all registered. Only `pred_rdy`/`res_rdy` are decoded combinationally, and only from registered occupancy.

## Test plan
- **Basic resolve.** Reset, then push pc=0x100 taken=1, then resolve taken=1. Required: `upd_en`=1, `upd_val`=1, `upd_pc`=0x100, `mispredict`=0 one cycle after the resolve. `n_branches`=1, `n_mispred`=0, occupancy returns to 0.
- **Fill and wrap.** Push DEPTH entries with pc=0x0,0x4,…,0x1C and check `pred_rdy`=0. Then assert push and pop together while full: the pop succeeds and the push is refused. Continue with 3×DEPTH mixed push/pop. Required: `upd_pc` sequence is strictly in push order across pointer wrap.
- **Mispredict flush.** Push 0x200 (taken=0), 0x204, 0x208, then resolve 0x200 with taken=1 while pushing 0x20C. Required: `mispredict`=1, `upd_val`=1, `upd_pc`=0x200. Occupancy is 0 next cycle, 0x20C is never resolvable, and `n_mispred`=1.
- **Empty resolve ignored.** Assert `res_val`=1 with the tracker empty. Required: no `upd_en`, counters unchanged.
- **Counter saturation.** Run with CNT_W=4 and perform 20 mispredicting resolves. Required: `n_branches`=`n_mispred`=15, held at that value.
- **Async reset mid-flight.** With occupancy 5 and `upd_en` high, drop `reset` between clock edges. Required: all outputs go to their reset values immediately, without waiting for `clk`. After release, a fresh push/resolve behaves as in the basic resolve scenario.
